// File: rtl/spi_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder_pkg
// Description : Opcodes, FSM state encoding and helpers shared by the SPI
//               command decoder and its sub-modules.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_decoder_pkg;

    // Command opcodes carried in the first byte of every frame
    localparam logic [7:0] OP_READ_COUNT = 8'h01;
    localparam logic [7:0] OP_WRITE_REG  = 8'h02;
    localparam logic [7:0] OP_READ_REG   = 8'h03;
    localparam logic [7:0] OP_START      = 8'h10;
    localparam logic [7:0] OP_STOP       = 8'h11;

    // Byte presented to the master before a command has been decoded
    localparam logic [7:0] DEF_IDLE_BYTE = 8'hA5;

    // Decoder FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_RCOUNT = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Select byte i of a 32-bit word, MSB first (i=0 -> [31:24])
    function automatic logic [7:0] count_byte(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] s;
        s = w >> {~i, 3'b000};
        return s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_decoder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder_sync_edge
// Description : 2-FF synchronizer for an asynchronous level, followed by a
//               third flop used for edge detection. rise/fall are single
//               clk-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder_sync_edge #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] holds the previous level
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw input through the chain
    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Chain resets to the idle level so no spurious edge follows reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {3{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder
// Description : System-clock command layer behind the SPI slave. Parses
//               framed commands, owns the config register file and the
//               photon-count readback, and selects the next MISO byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int         NREGS     = 8,
    parameter int         CNT_W     = 32,
    parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_n_async,
    input  logic               byte_busy,
    input  logic [7:0]         rx_byte,
    output logic [7:0]         tx_byte,
    input  logic [CNT_W-1:0]   count_in,
    output logic [NREGS*8-1:0] cfg_regs,
    output logic               cmd_start,
    output logic               cmd_stop,
    output logic               frame_err
);

    localparam int AW = $clog2(NREGS);

    logic cs_rise;
    logic cs_fall;
    logic byte_done;
    logic busy_rise_unused;

    state_t        state_q,    state_d;
    logic [AW-1:0] ptr_q,      ptr_d;
    logic          wr_q,       wr_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shadow_q,   shadow_d;
    logic [7:0]    tx_q,       tx_d;
    logic          start_q,    start_d;
    logic          stop_q,     stop_d;
    logic          err_q,      err_d;
    logic          reg_we;
    logic [AW-1:0] addr;
    logic          addr_bad;

    // Burst pointer advance with wrap for non power-of-two register counts
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(NREGS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Chip select idles high, busy idles low
    spi_cmd_decoder_sync_edge #(.RESET_LEVEL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n_async),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_cmd_decoder_sync_edge #(.RESET_LEVEL(1'b0)) u_busy_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (byte_busy),
        .rise (busy_rise_unused),
        .fall (byte_done)
    );

    assign addr     = rx_byte[AW-1:0];
    assign addr_bad = ({1'b0, rx_byte} >= 9'(NREGS));

    // Next-state, tx byte and pulse decode; a completed byte is handled before any cs edge
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        tx_d       = tx_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        err_d      = 1'b0;
        reg_we     = 1'b0;

        if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    case (rx_byte)
                        OP_READ_COUNT: begin
                            shadow_d   = 32'(count_in);
                            tx_d       = count_byte(32'(count_in), 2'd0);
                            byte_idx_d = 3'd1;
                            state_d    = ST_RCOUNT;
                        end
                        OP_WRITE_REG: begin
                            wr_d    = 1'b1;
                            state_d = ST_ADDR;
                        end
                        OP_READ_REG: begin
                            wr_d    = 1'b0;
                            state_d = ST_ADDR;
                        end
                        OP_START: begin
                            start_d = 1'b1;
                            tx_d    = 8'h00;
                            state_d = ST_IGNORE;
                        end
                        OP_STOP: begin
                            stop_d  = 1'b1;
                            tx_d    = 8'h00;
                            state_d = ST_IGNORE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            tx_d    = 8'h00;
                            state_d = ST_IGNORE;
                        end
                    endcase
                end
                ST_ADDR: begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        tx_d    = 8'h00;
                        state_d = ST_IGNORE;
                    end else if (wr_q) begin
                        ptr_d   = addr;
                        state_d = ST_WDATA;
                    end else begin
                        tx_d    = cfg_regs[{addr, 3'b000} +: 8];
                        ptr_d   = wrap_inc(addr);
                        state_d = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    reg_we = 1'b1;
                    ptr_d  = wrap_inc(ptr_q);
                end
                ST_RDATA: begin
                    tx_d  = cfg_regs[{ptr_q, 3'b000} +: 8];
                    ptr_d = wrap_inc(ptr_q);
                end
                ST_RCOUNT: begin
                    if (byte_idx_q != 3'd0 && byte_idx_q < 3'd4) begin
                        tx_d       = count_byte(shadow_q, byte_idx_q[1:0]);
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        tx_d = 8'h00;
                    end
                end
                ST_IGNORE: begin
                    tx_d = 8'h00;
                end
                default: begin
                    // IDLE: bytes outside a frame are dropped
                end
            endcase
        end

        if (cs_rise) begin
            state_d = ST_IDLE;
            tx_d    = IDLE_BYTE;
        end

        // A fall seen without its preceding rise restarts the frame
        if (cs_fall) begin
            state_d = ST_CMD;
            tx_d    = IDLE_BYTE;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            wr_q       <= 1'b0;
            byte_idx_q <= 3'd0;
            shadow_q   <= '0;
            tx_q       <= IDLE_BYTE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            byte_idx_q <= byte_idx_d;
            shadow_q   <= shadow_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
        end
    end

    // One 8-bit config register per slot, written from the burst pointer
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        logic [7:0] reg_q;
        logic [7:0] reg_d;

        // Load rx_byte when the burst pointer selects this slot
        always_comb begin
            reg_d = reg_q;
            if (reg_we && ptr_q == AW'(gi)) begin
                reg_d = rx_byte;
            end
        end

        // Register storage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                reg_q <= 8'h00;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign cfg_regs[8*gi +: 8] = reg_q;
    end

    assign tx_byte   = tx_q;
    assign cmd_start = start_q;
    assign cmd_stop  = stop_q;
    assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_decoder
// Description : Scoreboard bench for spi_cmd_decoder. Frames are modelled
//               at command level; expected tx/register state and expected
//               pulses are queued and checked by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_decoder;

    localparam logic [7:0] C_IDLE = 8'hA5;
    localparam int         C_NREGS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n_async = 1'b1;
    logic        byte_busy = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [31:0] count_in = 32'h0;
    logic [7:0]  tx_byte;
    logic [63:0] cfg_regs;
    logic        cmd_start;
    logic        cmd_stop;
    logic        frame_err;

    spi_cmd_decoder #(.NREGS(C_NREGS), .CNT_W(32), .IDLE_BYTE(C_IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n_async (cs_n_async),
        .byte_busy  (byte_busy),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .count_in   (count_in),
        .cfg_regs   (cfg_regs),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tx;
        logic [63:0] regs;
        string       name;
    } exp_t;

    exp_t       tx_q[$];
    logic [2:0] pulse_q[$];     // {start, stop, err}
    logic [7:0] mregs[C_NREGS];
    int         n_cmp = 0;
    int         n_fail = 0;
    event       ev_sample;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] pack_regs();
        logic [63:0] v;
        for (int i = 0; i < C_NREGS; i++) v[8*i +: 8] = mregs[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare tx byte and register file whenever the driver marks a settled byte
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            if (tx_q.size() == 0) begin
                chk("tx_queue_underflow", 64'd1, 64'd0);
            end else begin
                e = tx_q.pop_front();
                chk({e.name, "_tx"}, {56'd0, tx_byte}, {56'd0, e.tx});
                chk({e.name, "_regs"}, cfg_regs, e.regs);
            end
        end
    end

    // Monitor: every pulse the DUT presents must match the next expected pulse
    always @(negedge clk) begin
        if (!rst && (cmd_start || cmd_stop || frame_err)) begin
            if (pulse_q.size() == 0) begin
                chk("unexpected_pulse", {61'd0, cmd_start, cmd_stop, frame_err}, 64'd0);
            end else begin
                chk("pulse", {61'd0, cmd_start, cmd_stop, frame_err}, {61'd0, pulse_q.pop_front()});
            end
        end
    end

    // One SPI byte: busy high for a few clocks, then let the result settle
    task automatic send_byte(input logic [7:0] b, input logic [7:0] etx,
                             input logic [2:0] ep, input string nm);
        exp_t e;
        if (ep != 3'b000) pulse_q.push_back(ep);
        rx_byte   = b;
        byte_busy = 1'b1;
        tick(4);
        byte_busy = 1'b0;
        tick(6);
        e.tx   = etx;
        e.regs = pack_regs();
        e.name = nm;
        tx_q.push_back(e);
        -> ev_sample;
        tick(1);
    endtask

    // Whole frame, expected values derived from the command rules at frame level
    task automatic run_frame(input logic [7:0] fr[$], input string nm);
        logic [7:0]  op, adr, etx;
        logic [2:0]  ep;
        logic [31:0] snap;
        logic        valid;
        exp_t        e;
        op    = fr[0];
        adr   = (fr.size() > 1) ? fr[1] : 8'h00;
        valid = (int'(adr) < C_NREGS);
        snap  = 32'h0;
        cs_n_async = 1'b0;
        tick(4);
        for (int k = 0; k < fr.size(); k++) begin
            ep = 3'b000;
            if (op == 8'h01) begin
                if (k == 0) snap = count_in;
                etx = (k < 4) ? snap[8*(3-k) +: 8] : 8'h00;
            end else if (op == 8'h02 || op == 8'h03) begin
                if (k == 0) begin
                    etx = C_IDLE;
                end else if (!valid) begin
                    etx = 8'h00;
                    if (k == 1) ep = 3'b001;
                end else if (op == 8'h02) begin
                    etx = C_IDLE;
                    if (k >= 2) mregs[(int'(adr) + k - 2) % C_NREGS] = fr[k];
                end else begin
                    etx = mregs[(int'(adr) + k - 1) % C_NREGS];
                end
            end else begin
                etx = 8'h00;
                if (k == 0) ep = (op == 8'h10) ? 3'b100 : (op == 8'h11) ? 3'b010 : 3'b001;
            end
            send_byte(fr[k], etx, ep, nm);
            if (op == 8'h01 && k == 0) count_in = $urandom;
        end
        cs_n_async = 1'b1;
        tick(6);
        e.tx   = C_IDLE;
        e.regs = pack_regs();
        e.name = {nm, "_end"};
        tx_q.push_back(e);
        -> ev_sample;
        tick(1);
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] b;
        int         t, n;

        for (int i = 0; i < C_NREGS; i++) mregs[i] = 8'h00;

        // Reset state
        tick(3);
        chk("reset_tx", {56'd0, tx_byte}, {56'd0, C_IDLE});
        chk("reset_regs", cfg_regs, 64'd0);
        chk("reset_pulses", {61'd0, cmd_start, cmd_stop, frame_err}, 64'd0);
        rst = 1'b0;
        tick(3);

        // Directed cases
        f = {8'h02, 8'h03, 8'h11, 8'h22};         run_frame(f, "write_burst");
        f = {8'h02, 8'h07, 8'h5A, 8'hC3};         run_frame(f, "write_wrap");
        f = {8'h03, 8'h07, 8'h00, 8'h00};         run_frame(f, "read_wrap");
        count_in = 32'hDEADBEEF;
        f = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00};  run_frame(f, "count");
        f = {8'h7F, 8'h12};                       run_frame(f, "bad_opcode");
        f = {8'h02, 8'h08, 8'h99};                run_frame(f, "write_bad_addr");
        f = {8'h03, 8'h08, 8'h00};                run_frame(f, "read_bad_addr");
        f = {8'h02, 8'h01};                       run_frame(f, "cs_abort");
        f = {8'h10};                              run_frame(f, "start");
        f = {8'h11, 8'h33};                       run_frame(f, "stop");

        // Randomized frames
        for (int r = 0; r < 60; r++) begin
            f = {};
            t = $urandom_range(0, 5);
            case (t)
                0: begin f.push_back(8'h01); n = $urandom_range(0, 6); end
                1: begin f.push_back(8'h02); f.push_back(8'($urandom_range(0, 9))); n = $urandom_range(0, 10); end
                2: begin f.push_back(8'h03); f.push_back(8'($urandom_range(0, 9))); n = $urandom_range(0, 10); end
                3: begin f.push_back(8'h10); n = $urandom_range(0, 2); end
                4: begin f.push_back(8'h11); n = $urandom_range(0, 2); end
                default: begin
                    do b = 8'($urandom); while (b inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11});
                    f.push_back(b);
                    n = $urandom_range(0, 3);
                end
            endcase
            for (int j = 0; j < n; j++) f.push_back(8'($urandom));
            count_in = $urandom;
            run_frame(f, "random");
        end

        // Reset in the middle of a write burst
        cs_n_async = 1'b0;
        tick(4);
        send_byte(8'h02, C_IDLE, 3'b000, "rst_mid_op");
        send_byte(8'h01, C_IDLE, 3'b000, "rst_mid_addr");
        mregs[1] = 8'h77;
        send_byte(8'h77, C_IDLE, 3'b000, "rst_mid_data");
        #3 rst = 1'b1;
        #2;
        for (int i = 0; i < C_NREGS; i++) mregs[i] = 8'h00;
        chk("rst_mid_tx", {56'd0, tx_byte}, {56'd0, C_IDLE});
        chk("rst_mid_regs", cfg_regs, 64'd0);
        chk("rst_mid_pulses", {61'd0, cmd_start, cmd_stop, frame_err}, 64'd0);
        cs_n_async = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        f = {8'h03, 8'h00, 8'h00};                run_frame(f, "after_rst_read");
        f = {8'h10};                              run_frame(f, "after_rst_start");

        tick(10);
        for (int i = pulse_q.size(); i > 0; i--) begin
            chk("missing_pulse", 64'd0, {61'd0, pulse_q.pop_front()});
        end
        for (int i = tx_q.size(); i > 0; i--) begin
            void'(tx_q.pop_front());
            chk("unchecked_tx", 64'd1, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
